// File: rtl/mul_functional_unit_pkg.sv
// ----------------------------------------------------------------------------
// mul_functional_unit_pkg
// Shared definitions for the multiplier functional unit and its neighbours on
// the common data bus (ADD unit, CDB arbiter).
//   - DATA_W / TAG_W / CNT_W : default datapath, tag and iteration counter widths
//   - CDB_DATA_W / CDB_TAG_W : CDB field widths seen by every CDB producer
//   - mul_state_e            : MUL unit FSM state encoding
// ----------------------------------------------------------------------------
package mul_functional_unit_pkg;

    localparam int DATA_W = 8;
    localparam int TAG_W  = 3;
    localparam int CNT_W  = 4;

    localparam int CDB_DATA_W = DATA_W;
    localparam int CDB_TAG_W  = TAG_W;

    typedef enum logic [1:0] {
        MUL_IDLE  = 2'd0,
        MUL_EXEC  = 2'd1,
        MUL_BCAST = 2'd2
    } mul_state_e;

endpackage : mul_functional_unit_pkg

// File: rtl/mul_shift_add_datapath.sv
// ----------------------------------------------------------------------------
// mul_shift_add_datapath
// Iterative unsigned shift-add multiplier core, one partial product per step.
//   clk, rst         : clock, synchronous active-high reset
//   load_i           : capture operands, clear accumulator and counter
//   step_i           : perform one iteration
//   multiplicand_i   : multiplicand operand
//   multiplier_i     : multiplier operand
//   product_o        : accumulator value including the current iteration's
//                      partial product (the full product on the last step)
//   done_o           : the current step is the final (DATA_W-th) iteration
// ----------------------------------------------------------------------------
module mul_shift_add_datapath #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                step_i,
    input  logic [DATA_W-1:0]   multiplicand_i,
    input  logic [DATA_W-1:0]   multiplier_i,
    output logic [2*DATA_W-1:0] product_o,
    output logic                done_o
);

    logic [DATA_W-1:0]   mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] acc_d;
    logic [2*DATA_W-1:0] partial;
    logic [CNT_W-1:0]    cnt_q;

    // The multiplier is shifted right each step, so its LSB always selects the
    // bit for the current count; the multiplicand is shifted by count instead.
    always_comb begin
        partial   = mplier_q[0] ? ({{DATA_W{1'b0}}, mcand_q} << cnt_q) : '0;
        acc_d     = acc_q + partial;
        product_o = acc_d;
        done_o    = (cnt_q == CNT_W'(DATA_W - 1));
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            mcand_q  <= multiplicand_i;
            mplier_q <= multiplier_i;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step_i) begin
            acc_q    <= acc_d;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

endmodule : mul_shift_add_datapath

// File: rtl/mul_functional_unit.sv
// ----------------------------------------------------------------------------
// mul_functional_unit
// Multiplier execution unit fed by the MUL reservation station. Accepts an
// operand pair plus tag, runs DATA_W shift-add iterations, then requests the
// CDB and holds the result until granted.
//   clk, rst       : clock, synchronous active-high reset
//   MR_Status      : dispatch valid from the station
//   MUL_Tag_ip     : destination tag of the dispatched op
//   MUL_Operand3   : multiplicand
//   MUL_Operand4   : multiplier
//   MUL_Status     : unit busy, station must not dispatch
//   CDB_Req        : CDB request, held until CDB_Grant
//   CDB_Grant      : arbiter grant
//   CDB_Data       : low DATA_W bits of the product
//   CDB_Tag        : tag of the broadcast result
//   CDB_Ovf        : upper DATA_W product bits are nonzero
// ----------------------------------------------------------------------------
module mul_functional_unit
    import mul_functional_unit_pkg::*;
#(
    parameter int DATA_W = mul_functional_unit_pkg::DATA_W,
    parameter int TAG_W  = mul_functional_unit_pkg::TAG_W,
    parameter int CNT_W  = mul_functional_unit_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MR_Status,
    input  logic [TAG_W-1:0]  MUL_Tag_ip,
    input  logic [DATA_W-1:0] MUL_Operand3,
    input  logic [DATA_W-1:0] MUL_Operand4,
    output logic              MUL_Status,
    output logic              CDB_Req,
    input  logic              CDB_Grant,
    output logic [DATA_W-1:0] CDB_Data,
    output logic [TAG_W-1:0]  CDB_Tag,
    output logic              CDB_Ovf
);

    mul_state_e          state_q, state_d;
    logic                status_q, status_d;
    logic                req_q, req_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                ovf_q, ovf_d;
    logic [TAG_W-1:0]    op_tag_q, op_tag_d;

    logic                dp_load;
    logic                dp_step;
    logic [2*DATA_W-1:0] dp_product;
    logic                dp_done;

    mul_shift_add_datapath #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_datapath (
        .clk            (clk),
        .rst            (rst),
        .load_i         (dp_load),
        .step_i         (dp_step),
        .multiplicand_i (MUL_Operand3),
        .multiplier_i   (MUL_Operand4),
        .product_o      (dp_product),
        .done_o         (dp_done)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        req_d    = req_q;
        data_d   = data_q;
        tag_d    = tag_q;
        ovf_d    = ovf_q;
        op_tag_d = op_tag_q;
        dp_load  = 1'b0;
        dp_step  = 1'b0;

        unique case (state_q)
            MUL_IDLE: begin
                if (MR_Status) begin
                    dp_load  = 1'b1;
                    op_tag_d = MUL_Tag_ip;
                    status_d = 1'b1;
                    state_d  = MUL_EXEC;
                end
            end
            MUL_EXEC: begin
                dp_step = 1'b1;
                // Result is captured from the combinational product so the
                // final iteration is included on the same edge.
                if (dp_done) begin
                    data_d  = dp_product[DATA_W-1:0];
                    ovf_d   = |dp_product[2*DATA_W-1:DATA_W];
                    tag_d   = op_tag_q;
                    req_d   = 1'b1;
                    state_d = MUL_BCAST;
                end
            end
            MUL_BCAST: begin
                // Data and tag are left as-is after the grant; they are
                // don't-care while the request is low.
                if (CDB_Grant) begin
                    req_d    = 1'b0;
                    status_d = 1'b0;
                    state_d  = MUL_IDLE;
                end
            end
            default: begin
                state_d = MUL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MUL_IDLE;
            status_q <= 1'b0;
            req_q    <= 1'b0;
            data_q   <= '0;
            tag_q    <= '0;
            ovf_q    <= 1'b0;
            op_tag_q <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            req_q    <= req_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
            ovf_q    <= ovf_d;
            op_tag_q <= op_tag_d;
        end
    end

    assign MUL_Status = status_q;
    assign CDB_Req    = req_q;
    assign CDB_Data   = data_q;
    assign CDB_Tag    = tag_q;
    assign CDB_Ovf    = ovf_q;

endmodule : mul_functional_unit
